// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RISC-V immediate generator: format enum,
// opcode constants and the buffered entry layout.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_Z  = 3'd6,
        FMT_SH = 3'd7
    } imm_fmt_t;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_OP_32   = 7'b0111011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    // Entries are sized for the widest configuration; narrower builds leave
    // the upper bits at zero.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_t             fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh, imm_sh32;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_shift = (funct3[1:0] == 2'b01);

    assign imm_i    = XLEN'($signed(inst[31:20]));
    assign imm_s    = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign imm_z    = XLEN'(inst[19:15]);
    // Shift amount is 6 bits wide on RV64, 5 bits on RV32 and for *W shifts.
    assign imm_sh   = RV64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    assign imm_sh32 = XLEN'(inst[24:20]);

    always_comb begin
        imm     = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                fmt = FMT_I;
                imm = imm_i;
            end
            OP_IMM: begin
                if (is_shift) begin
                    fmt = FMT_SH;
                    imm = imm_sh;
                end else begin
                    fmt = FMT_I;
                    imm = imm_i;
                end
            end
            OP_IMM_32: begin
                if (!RV64) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    fmt = FMT_SH;
                    imm = imm_sh32;
                end else begin
                    fmt = FMT_I;
                    imm = imm_i;
                end
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = imm_s;
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = imm_u;
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = imm_j;
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    fmt = FMT_Z;
                    imm = imm_z;
                end
            end
            OP_OP: ;
            OP_OP_32: illegal = !RV64;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode at the input, 2-entry output FIFO,
// flush, and a saturating count of accepted illegal words.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic            head_ptr_reg, tail_ptr_reg;
    logic [1:0]      count_reg;
    logic            push, pop;
    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            dec_illegal;
    entry_t          new_entry;
    entry_t          head;
    entry_t          slot [2];

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // in_ready looks only at the registered fill level, never at out_ready.
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        new_entry                  = '0;
        new_entry.imm[XLEN-1:0]    = dec_imm;
        new_entry.fmt              = dec_fmt;
        new_entry.illegal          = dec_illegal;
        new_entry.tag[TAG_W-1:0]   = in_tag;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        localparam logic SLOT_ID = 1'(gi);
        entry_t entry_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= '0;
            end else if (push && (tail_ptr_reg == SLOT_ID)) begin
                entry_reg <= new_entry;
            end
        end

        assign slot[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr_reg <= 1'b0;
            tail_ptr_reg <= 1'b0;
            count_reg    <= 2'd0;
        end else if (flush) begin
            head_ptr_reg <= 1'b0;
            tail_ptr_reg <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            if (push) tail_ptr_reg <= !tail_ptr_reg;
            if (pop)  head_ptr_reg <= !head_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (push && dec_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign head        = slot[head_ptr_reg];
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;
    assign out_tag     = head.tag[TAG_W-1:0];

    // Padding bits above XLEN / TAG_W are always zero and intentionally unread.
    logic [IMM_MAX_W+TAG_MAX_W-1:0] unused_head_bits;
    assign unused_head_bits = {head.imm, head.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: one RV64 and one RV32 instance share the same stimulus;
// a behavioural decoder model fills per-instance queues checked by a monitor.
module tb_imm_gen_pipe;

    localparam int TAG_W = 16;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic             rdy64, ov64, ill64;
    logic [63:0]      imm64;
    logic [2:0]       fmt64;
    logic [TAG_W-1:0] tag64;
    logic [CNT_W-1:0] cnt64;
    logic             rdy32, ov32, ill32;
    logic [31:0]      imm32;
    logic [2:0]       fmt32;
    logic [TAG_W-1:0] tag32;
    logic [CNT_W-1:0] cnt32;

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_tag(in_tag), .flush(flush),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64),
        .illegal_cnt(cnt64)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_tag(in_tag), .flush(flush),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32),
        .illegal_cnt(cnt32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    int   exp_cnt64 = 0;
    int   exp_cnt32 = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    logic [TAG_W-1:0] tag_ctr = 16'h0001;

    logic [6:0] op_tab [12] = '{7'h03, 7'h13, 7'h1B, 7'h17, 7'h23, 7'h33,
                                7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint unsigned v, input int bits);
        if (((v >> (bits - 1)) & 64'd1) != 0) return longint'(v) - (longint'(1) << bits);
        return longint'(v);
    endfunction

    // Immediate rules written as plain field arithmetic on the instruction word.
    function automatic exp_t ref_model(input logic [31:0] w, input logic [TAG_W-1:0] tag, input int xlen);
        longint unsigned u = 64'(w);
        int     op = int'(w[6:0]);
        int     f3 = int'(w[14:12]);
        bit     shift = (f3 == 1) || (f3 == 5);
        longint v = 0;
        exp_t   e;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tag;
        case (op)
            'h03, 'h67: begin e.fmt = 3'd1; v = sx((u >> 20) & 'hfff, 12); end
            'h13: begin
                if (shift) begin
                    e.fmt = 3'd7;
                    v = (xlen == 64) ? longint'((u >> 20) & 63) : longint'((u >> 20) & 31);
                end else begin
                    e.fmt = 3'd1; v = sx((u >> 20) & 'hfff, 12);
                end
            end
            'h1b: begin
                if (xlen != 64) e.ill = 1'b1;
                else if (shift) begin e.fmt = 3'd7; v = longint'((u >> 20) & 31); end
                else begin e.fmt = 3'd1; v = sx((u >> 20) & 'hfff, 12); end
            end
            'h23: begin
                e.fmt = 3'd2;
                v = sx((((u >> 25) & 127) << 5) | ((u >> 7) & 31), 12);
            end
            'h63: begin
                e.fmt = 3'd3;
                v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                       (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
            end
            'h37, 'h17: begin e.fmt = 3'd4; v = sx(u & 'hfffff000, 32); end
            'h6f: begin
                e.fmt = 3'd5;
                v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                       (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
            end
            'h73: if (f3 >= 4) begin e.fmt = 3'd6; v = longint'((u >> 15) & 31); end
            'h33: ;
            'h3b: e.ill = (xlen != 64);
            default: e.ill = 1'b1;
        endcase
        e.imm = (xlen == 64) ? 64'(v) : {32'd0, v[31:0]};
        return e;
    endfunction

    // One clock cycle of stimulus; the model is updated at the edge that commits it.
    task automatic drive(input bit v, input logic [31:0] w, input bit fl, input bit ordy);
        bit   acc;
        exp_t e;
        in_valid  = v;
        in_inst   = w;
        in_tag    = tag_ctr;
        flush     = fl;
        out_ready = ordy;
        acc = v && rdy64 && !fl;
        @(posedge clk);
        if (fl) begin
            q64.delete();
            q32.delete();
        end else if (acc) begin
            e = ref_model(w, tag_ctr, 64);
            q64.push_back(e);
            if (e.ill && exp_cnt64 < CNT_MAX) exp_cnt64++;
            e = ref_model(w, tag_ctr, 32);
            q32.push_back(e);
            if (e.ill && exp_cnt32 < CNT_MAX) exp_cnt32++;
            tag_ctr++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid64", 64'(ov64), 64'(q64.size() != 0));
            chk("ready64", 64'(rdy64), 64'(q64.size() != 2));
            chk("cnt64", 64'(cnt64), 64'(exp_cnt64));
            chk("valid32", 64'(ov32), 64'(q32.size() != 0));
            chk("ready32", 64'(rdy32), 64'(q32.size() != 2));
            chk("cnt32", 64'(cnt32), 64'(exp_cnt32));
            if (ov64 && q64.size() != 0) begin
                chk("imm64", imm64, q64[0].imm);
                chk("fmt64", 64'(fmt64), 64'(q64[0].fmt));
                chk("ill64", 64'(ill64), 64'(q64[0].ill));
                chk("tag64", 64'(tag64), 64'(q64[0].tag));
                if (out_ready) begin
                    $display("txn tag=%h imm=%h fmt=%0d illegal=%0d", tag64, imm64, fmt64, ill64);
                    void'(q64.pop_front());
                end
            end
            if (ov32 && q32.size() != 0) begin
                chk("imm32", {32'd0, imm32}, q32[0].imm);
                chk("fmt32", 64'(fmt32), 64'(q32[0].fmt));
                chk("ill32", 64'(ill32), 64'(q32[0].ill));
                chk("tag32", 64'(tag32), 64'(q32[0].tag));
                if (out_ready) void'(q32.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        #12;
        chk("rst_valid64", 64'(ov64), 64'd0);
        chk("rst_ready64", 64'(rdy64), 64'd1);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_fmt64", 64'(fmt64), 64'd0);
        chk("rst_tag64", 64'(tag64), 64'd0);
        chk("rst_cnt64", 64'(cnt64), 64'd0);
        chk("rst_valid32", 64'(ov32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // addi -1, then a back-to-back S/B/U/J burst
        drive(1, 32'hFFF00093, 0, 1);
        drive(0, 32'h0, 0, 1);
        drive(1, 32'h0020A423, 0, 1);
        drive(1, 32'hFE000EE3, 0, 1);
        drive(1, 32'h800002B7, 0, 1);
        drive(1, 32'h0040006F, 0, 1);
        drive(0, 32'h0, 0, 1);
        drive(0, 32'h0, 0, 1);

        // backpressure: third word held until space frees
        drive(1, 32'h00500113, 0, 0);
        drive(1, 32'h00A00193, 0, 0);
        drive(1, 32'h00F00213, 0, 0);
        drive(1, 32'h00F00213, 0, 0);
        drive(1, 32'h00F00213, 0, 1);
        drive(1, 32'h00F00213, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 0, 1);

        // RV32-specific words
        drive(1, 32'h01F09093, 0, 1);
        drive(1, 32'h0000001B, 0, 1);
        drive(1, 32'h0000007F, 0, 1);
        drive(0, 32'h0, 0, 1);
        drive(0, 32'h0, 0, 1);

        // full buffer, flush with an illegal word on the input
        drive(1, 32'h00100093, 0, 0);
        drive(1, 32'h00200093, 0, 0);
        drive(1, 32'h0000007F, 1, 1);
        drive(0, 32'h0, 0, 1);
        drive(0, 32'h0, 0, 1);

        // saturate the illegal counter
        for (int i = 0; i < CNT_MAX + 4; i++) drive(1, 32'h0000007F, 0, 1);
        drive(0, 32'h0, 0, 1);

        // asynchronous reset mid-transfer with a full buffer
        drive(1, 32'h00300093, 0, 0);
        drive(1, 32'h00400093, 0, 0);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid64", 64'(ov64), 64'd0);
        chk("arst_ready64", 64'(rdy64), 64'd1);
        chk("arst_cnt64", 64'(cnt64), 64'd0);
        chk("arst_valid32", 64'(ov32), 64'd0);
        chk("arst_cnt32", 64'(cnt32), 64'd0);
        q64.delete();
        q32.delete();
        exp_cnt64 = 0;
        exp_cnt32 = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) != 0) w[6:0] = op_tab[$urandom_range(0, 11)];
            drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 4; i++) drive(0, 32'h0, 0, 1);

        chk("drain64", 64'(q64.size()), 64'd0);
        chk("drain32", 64'(q32.size()), 64'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V decode stage. Takes a full 32-bit instruction word over a valid/ready handshake and classifies it into one of eight immediate formats (R, I, S, B, U, J, CSR-zimm, shift-amount). It returns an XLEN-wide sign- or zero-extended immediate, an illegal-opcode flag and a passthrough tag through a 2-entry output buffer. Sits between fetch and the register-read stage. Supersedes the combinational 5-bit-opcode generator.

## Interface
- `XLEN`, 64: immediate width; legal values 32 or 64.
- `TAG_W`, 64: width of the passthrough tag (PC or instruction id).
- `CNT_W`, 16: width of the illegal-instruction counter.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word.
- `in_inst`  in  32  instruction; bit 0 is the LSB; opcode is `[6:0]`.
- `in_tag`  in  TAG_W  carried unchanged to the output.
- `flush`  in  1  synchronous discard of all buffered entries.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_imm`  out  XLEN  generated immediate.
- `out_fmt`  out  3  `imm_fmt_t` of the head entry.
- `out_illegal`  out  1  unrecognised opcode.
- `out_tag`  out  TAG_W  tag of the head entry.
- `illegal_cnt`  out  CNT_W  saturating count of accepted illegal words.

## Operation
- Accept a word when `in_valid && in_ready`. Push is blocked while `flush` is high.
- Decode, with sext meaning sign-extension to XLEN from the top listed bit:
  - LOAD 0000011, JALR 1100111, OP-IMM 0010011 (funct3 ≠ 001/101): format I, sext `inst[31:20]`.
  - OP-IMM with funct3 001/101: format SH. Zero-extend `inst[25:20]` when XLEN=64, `inst[24:20]` when XLEN=32.
  - OP-IMM-32 0011011: legal only when XLEN=64. Shifts (funct3 001/101) use format SH, zero-extended `inst[24:20]`; otherwise format I.
  - STORE 0100011: format S, sext `{inst[31:25],inst[11:7]}`.
  - BRANCH 1100011: format B, sext `{inst[31],inst[7],inst[30:25],inst[11:8],1'b0}`.
  - LUI 0110111 and AUIPC 0010111: format U, sext `{inst[31:12],12'b0}`.
  - JAL 1101111: format J, sext `{inst[31],inst[19:12],inst[20],inst[30:21],1'b0}`.
  - SYSTEM 1110011, funct3[2]=1: format Z, zero-extend `inst[19:15]`. Other SYSTEM, OP 0110011, OP-32 0111011 (OP-32 only when XLEN=64): format R, imm 0.
  - Anything else: format R, imm 0, illegal=1.
- Output buffer: 2-entry FIFO with registered count (0..2).
  - `in_ready = (count != 2)`; it depends only on the registered count, never on `out_ready`.
  - Push and pop in the same cycle leave count unchanged. Order is strictly preserved.
- `flush`: count←0 next edge. It has priority over a simultaneous push and pop; the pushed word is dropped and `illegal_cnt` is not incremented.
- `illegal_cnt` increments on each accepted illegal word and saturates at all-ones. Only reset clears it.

## Timing
- Latency: a word accepted at edge N is visible at the output after edge N (out_valid=1 in cycle N+1) when the buffer was empty. Otherwise it appears behind older entries.
- Throughput: 1 word/cycle while `out_ready=1`.
- All outputs are registered or driven from a register with a mux on the head pointer. There are no combinational paths from `in_*` to `out_*`.
- Reset values: `out_valid`=0, `out_imm`=0, `out_fmt`=R (0), `out_illegal`=0, `out_tag`=0, `illegal_cnt`=0, count=0, so `in_ready`=1. Pointers are 0.
- Reset asserted mid-transfer discards all entries immediately, asynchronously.
- Output data is stable while `out_valid && !out_ready`.

## Structure
- Package `imm_gen_pkg` holds:
  - `imm_fmt_t` (R=0, I=1, S=2, B=3, U=4, J=5, Z=6, SH=7).
  - The opcode localparams.
  - The entry struct {imm, fmt, illegal, tag}.
- Sub-module `imm_decode`: purely combinational `inst` → {imm, fmt, illegal}, parametrised by XLEN.
- The top level holds the FIFO, handshake, flush and counter.

## Test plan
- XLEN=64, push 0xFFF00093 (addi -1) → next cycle imm=0xFFFF_FFFF_FFFF_FFFF, fmt=I, illegal=0.
- Push 0x0020A423 (sw 8), 0xFE000EE3 (beq -4), 0x800002B7 (lui 0x80000), 0x0040006F (jal 4) back-to-back with out_ready=1 → imm 8/S, 0xFFFF_FFFF_FFFF_FFFC/B, 0xFFFF_FFFF_8000_0000/U, 4/J, one per cycle. Tags match.
- out_ready=0, push three words → in_ready drops after two and the third is held. Raise out_ready → all three emerge in order with no loss.
- Push 0x0000007F → illegal=1, imm=0, illegal_cnt 0→1. Force the count to all-ones and push another → the count holds.
- Buffer full, assert flush together with in_valid → next cycle out_valid=0, count=0, pushed word dropped.
- XLEN=32: 0x01F09093 (slli 31) → SH, imm=31. 0x0000001B (OP-IMM-32) → illegal=1.
